// File: rtl/forth_stack.sv
// Data stack with a cached top of stack (tos/s0/s1 exposed), one operation per clock, no stalls.
// Define FORTH_STACK_GUARD_EN to turn err into a sticky overflow/underflow flag; otherwise err is 0.
module forth_stack #(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [2:0]             op,
    input  logic [DSZ-1:0]         vi,
    output logic [DSZ-1:0]         tos,
    output logic [DSZ-1:0]         s0,
    output logic [DSZ-1:0]         s1,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5,
        OP_ROT  = 3'd6,
        OP_LOAD = 3'd7
    } op_e;

    // Handshake: en acts as valid; the stack is always ready, so every
    // cycle with en=1 consumes exactly one op at the rising edge.
    op_e             op_w;
    logic [DSZ-1:0]  stk_q [DEPTH];
    logic [DSZ-1:0]  stk_d [DEPTH];
    logic [DW-1:0]   depth_q, depth_d;
    logic            full_q, empty_q;
    logic [DW-1:0]   need;
    logic            grow;
    logic            underflow, overflow;
    logic [DSZ-1:0]  push_val;

    assign op_w = op_e'(op);

    always_comb begin
        stk_d    = stk_q;
        depth_d  = depth_q;
        need     = '0;
        grow     = 1'b0;
        push_val = vi;
        case (op_w)
            OP_PUSH: grow = 1'b1;
            OP_POP:  need = DW'(1);
            OP_LOAD: need = DW'(1);
            OP_DUP: begin
                need     = DW'(1);
                grow     = 1'b1;
                push_val = stk_q[0];
            end
            OP_SWAP: need = DW'(2);
            OP_OVER: begin
                need     = DW'(2);
                grow     = 1'b1;
                push_val = stk_q[1];
            end
            OP_ROT:  need = DW'(3);
            default: ;
        endcase

        underflow = en && (depth_q < need);
        overflow  = en && grow && (depth_q == DEPTH_V);

        // Cells at or beyond depth are kept at zero, so tos/s0/s1 read 0 there.
        if (en && !underflow && !overflow) begin
            if (grow) begin
                for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                stk_d[0] = push_val;
                depth_d  = depth_q + DW'(1);
            end else begin
                case (op_w)
                    OP_POP: begin
                        for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                        stk_d[DEPTH-1] = '0;
                        depth_d        = depth_q - DW'(1);
                    end
                    OP_SWAP: begin
                        stk_d[0] = stk_q[1];
                        stk_d[1] = stk_q[0];
                    end
                    OP_ROT: begin
                        stk_d[0] = stk_q[2];
                        stk_d[1] = stk_q[0];
                        stk_d[2] = stk_q[1];
                    end
                    OP_LOAD: stk_d[0] = vi;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            stk_q   <= stk_d;
            depth_q <= depth_d;
            full_q  <= (depth_d == DEPTH_V);
            empty_q <= (depth_d == '0);
        end
    end

`ifdef FORTH_STACK_GUARD_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (underflow || overflow) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign tos   = stk_q[0];
    assign s0    = stk_q[1];
    assign s1    = stk_q[2];
    assign depth = depth_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_forth_stack.sv
// Directed bench for forth_stack (DEPTH=16, DSZ=32): fill/drain, stack words, guards, en, LOAD, async reset.
module tb_forth_stack;

    localparam int DEPTH = 16;
    localparam int DSZ   = 32;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_OVER = 3'd5;
    localparam logic [2:0] OP_ROT  = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

`ifdef FORTH_STACK_GUARD_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [2:0]             op;
    logic [DSZ-1:0]         vi;
    logic [DSZ-1:0]         tos;
    logic [DSZ-1:0]         s0;
    logic [DSZ-1:0]         s1;
    logic [$clog2(DEPTH):0] depth;
    logic                   full;
    logic                   empty;
    logic                   err;

    int n_cmp;
    int n_mis;

    forth_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .op    (op),
        .vi    (vi),
        .tos   (tos),
        .s0    (s0),
        .s1    (s1),
        .depth (depth),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_stack(input string tag, input logic [31:0] e_tos, input logic [31:0] e_s0,
                               input logic [31:0] e_s1, input int e_depth);
        check({tag, ".tos"},   tos, e_tos);
        check({tag, ".s0"},    s0, e_s0);
        check({tag, ".s1"},    s1, e_s1);
        check({tag, ".depth"}, 32'(depth), 32'(e_depth));
        check({tag, ".full"},  32'(full), (e_depth == DEPTH) ? 32'd1 : 32'd0);
        check({tag, ".empty"}, 32'(empty), (e_depth == 0) ? 32'd1 : 32'd0);
    endtask

    // driver: inputs change on the falling edge, so the op is taken at the next rising edge
    task automatic drive(input logic [2:0] o, input logic [31:0] v, input logic e);
        @(negedge clk);
        en = e;
        op = o;
        vi = v;
    endtask

    // idle one cycle; on return the previously driven op is visible on the outputs
    task automatic settle();
        drive(OP_NOP, 32'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_stack("async_rst", 32'd0, 32'd0, 32'd0, 0);
        check("async_rst.err", 32'(err), 32'd0);
        #1 rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b0;
        en    = 1'b0;
        op    = OP_NOP;
        vi    = '0;

        repeat (2) @(negedge clk);
        check_stack("reset", 32'd0, 32'd0, 32'd0, 0);
        check("reset.err", 32'(err), 32'd0);
        rst = 1'b1;

        // fill 0..15, back to back
        for (int i = 0; i < DEPTH; i++) drive(OP_PUSH, 32'(i), 1'b1);
        settle();
        check_stack("fill", 32'hf, 32'he, 32'hd, 16);
        check("fill.err", 32'(err), 32'd0);

        // overflow leaves contents alone
        drive(OP_PUSH, 32'hdead, 1'b1);
        settle();
        check_stack("ovf", 32'hf, 32'he, 32'hd, 16);
        check("ovf.err", 32'(err), ERR_EXP);

        // drain in LIFO order
        for (int i = DEPTH - 1; i >= 0; i--) begin
            check($sformatf("drain%0d.tos", i), tos, 32'(i));
            check($sformatf("drain%0d.s0", i), s0, (i >= 1) ? 32'(i - 1) : 32'd0);
            drive(OP_POP, 32'd0, 1'b1);
            settle();
        end
        check_stack("drained", 32'd0, 32'd0, 32'd0, 0);

        // POP on empty stack
        drive(OP_POP, 32'd0, 1'b1);
        settle();
        check_stack("pop_empty", 32'd0, 32'd0, 32'd0, 0);

        // stack words on a fresh stack
        pulse_reset();
        drive(OP_PUSH, 32'd1, 1'b1);
        drive(OP_PUSH, 32'd2, 1'b1);
        drive(OP_PUSH, 32'd3, 1'b1);
        settle();
        check_stack("p123", 32'd3, 32'd2, 32'd1, 3);
        drive(OP_ROT, 32'd0, 1'b1);
        settle();
        check_stack("rot", 32'd1, 32'd3, 32'd2, 3);
        drive(OP_SWAP, 32'd0, 1'b1);
        settle();
        check_stack("swap", 32'd3, 32'd1, 32'd2, 3);
        drive(OP_OVER, 32'd0, 1'b1);
        settle();
        check_stack("over", 32'd1, 32'd3, 32'd1, 4);
        drive(OP_DUP, 32'd0, 1'b1);
        settle();
        check_stack("dup", 32'd1, 32'd1, 32'd3, 5);
        check("words.err", 32'(err), 32'd0);
        // expected [1,1,3,1,2]; pop back to back and check the deep items surfaced intact
        drive(OP_POP, 32'd0, 1'b1);
        drive(OP_POP, 32'd0, 1'b1);
        settle();
        check_stack("words_pop2", 32'd3, 32'd1, 32'd2, 3);

        // mixed ops back to back, no idle cycles: [3,1,2] -> SWAP [1,3,2] -> DUP [1,1,3,2] -> ROT [3,1,1,2] -> OVER [1,3,1,1,2]
        drive(OP_SWAP, 32'd0, 1'b1);
        drive(OP_DUP, 32'd0, 1'b1);
        drive(OP_ROT, 32'd0, 1'b1);
        drive(OP_OVER, 32'd0, 1'b1);
        settle();
        check_stack("b2b", 32'd1, 32'd3, 32'd1, 5);

        // underflow, en=0 and LOAD
        pulse_reset();
        drive(OP_PUSH, 32'd9, 1'b1);
        drive(OP_PUSH, 32'd8, 1'b1);
        settle();
        check_stack("d2", 32'd8, 32'd9, 32'd0, 2);
        drive(OP_ROT, 32'd0, 1'b1);
        settle();
        check_stack("rot_unf", 32'd8, 32'd9, 32'd0, 2);
        check("rot_unf.err", 32'(err), ERR_EXP);
        drive(OP_PUSH, 32'h77, 1'b0);
        settle();
        check_stack("en0", 32'd8, 32'd9, 32'd0, 2);
        drive(OP_PUSH, 32'd4, 1'b1);
        drive(OP_LOAD, 32'h55, 1'b1);
        settle();
        check_stack("load", 32'h55, 32'd8, 32'd9, 3);

        // reset mid-operation at depth 5
        pulse_reset();
        for (int i = 1; i <= 5; i++) drive(OP_PUSH, 32'(i), 1'b1);
        settle();
        check_stack("d5", 32'd5, 32'd4, 32'd3, 5);
        pulse_reset();
        drive(OP_PUSH, 32'd7, 1'b1);
        settle();
        check_stack("after_rst", 32'd7, 32'd0, 32'd0, 1);
        check("after_rst.err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/forth_stack.md
FORTH_STACK -- requirements
Module: forth_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning total stack capacity in cells, including the cached TOS.
REQ-002 The block SHALL have parameter DSZ, default 32, meaning cell width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: operation enable; op is ignored when en=0.
REQ-006 The block SHALL have port op, input, 3 bits: opcode (0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 ROT, 7 LOAD).
REQ-007 The block SHALL have port vi, input, DSZ bits: value for PUSH/LOAD.
REQ-008 The block SHALL have port tos, output, DSZ bits: top of stack.
REQ-009 The block SHALL have port s0, output, DSZ bits: second item.
REQ-010 The block SHALL have port s1, output, DSZ bits: third item.
REQ-011 The block SHALL have port depth, output, $clog2(DEPTH)+1 bits: item count, 0..DEPTH.
REQ-012 The block SHALL have ports full and empty, outputs, 1 bit each: depth==DEPTH and depth==0 respectively.
REQ-013 The block SHALL have port err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-014 All outputs SHALL be registered; an op sampled at rising edge N SHALL be visible on tos/s0/s1/depth after edge N, with one-op-per-cycle throughput and no stalls.
REQ-015 tos/s0/s1 SHALL read 0 for any position at or beyond depth.
REQ-016 PUSH SHALL set tos<=vi and shift the stack down one position; depth+1.
REQ-017 POP SHALL shift the stack up one position (tos<=s0); depth-1.
REQ-018 DUP SHALL push a copy of tos; depth+1.
REQ-019 SWAP SHALL exchange tos and s0; depth unchanged.
REQ-020 OVER SHALL push a copy of s0; depth+1.
REQ-021 ROT SHALL move s1 to tos, old tos to s0, and old s0 to s1; depth unchanged.
REQ-022 LOAD SHALL set tos<=vi with depth unchanged, as an ALU result write-back.
REQ-023 NOP, or any op with en=0, SHALL change no state.
REQ-024 Minimum depth requirements SHALL be: POP/DUP/LOAD >=1, SWAP/OVER >=2, ROT >=3; an op below its minimum is an underflow.
REQ-025 PUSH/DUP/OVER at depth==DEPTH SHALL be an overflow.
REQ-026 An overflowing or underflowing op SHALL change no stack contents and no depth.
REQ-027 Items below s1 SHALL be preserved bit-exact across every op; a full stack of DEPTH items SHALL be poppable in LIFO order.
REQ-028 Each legal op SHALL execute independently of the previous cycle's op; back-to-back mixed ops SHALL need no idle cycles.

Reset
REQ-029 On rst=0 the block SHALL immediately (asynchronously) force tos=s0=s1=0, depth=0, empty=1, full=0, err=0.
REQ-030 Reset asserted mid-sequence SHALL discard all contents; the first op after deassertion SHALL behave as on a fresh empty stack.

Configuration
REQ-031 When macro FORTH_STACK_GUARD_EN is defined, any overflow or underflow SHALL set err=1 at the same edge, and err SHALL hold until reset.
REQ-032 When FORTH_STACK_GUARD_EN is undefined, err SHALL be constant 0 and illegal ops SHALL be silently treated as NOP per REQ-026.

Verification
REQ-033 The bench SHALL cover fill/drain: after reset, PUSH 0..15 with DEPTH=16 -> full=1, tos=f, s0=e, s1=d; then 16 POPs -> tos 0xf..0x0 in order, then empty=1, tos=0.
REQ-034 The bench SHALL cover stack words: PUSH 1, PUSH 2, PUSH 3 -> ROT gives [1,3,2]; SWAP gives [3,1,2]; OVER gives [1,3,1,2] with depth=4; DUP gives depth=5, tos=1.
REQ-035 The bench SHALL cover overflow: when full, PUSH 0xdead -> contents and depth unchanged; err=1 with guard, err=0 without.
REQ-036 The bench SHALL cover underflow: at depth=2, ROT -> no change, err per REQ-031/032; at depth=0, POP -> tos=0, depth=0.
REQ-037 The bench SHALL cover en and LOAD: en=0 with op=PUSH -> no change; at depth=3, LOAD 0x55 -> tos=0x55, s0/s1/depth unchanged.
REQ-038 The bench SHALL cover reset mid-operation: with depth=5, pulse rst low between edges -> outputs zero immediately; next PUSH 7 gives depth=1, tos=7, err=0.
